// File: rtl/mem_subsys_pkg.sv
// Shared types and defaults for the mem_subsystem data-memory block.
package mem_subsys_pkg;

    typedef enum logic [1:0] {IDLE, RAM, MMIO, RESP} state_e;

    typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_NONE} region_e;

    localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hFF00;

endpackage

// File: rtl/mem_subsys_ram.sv
// Single-port synchronous RAM with a registered read port; contents are not reset.
module mem_subsys_ram
    import mem_subsys_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_subsystem.sv
// Decoded RAM / MMIO data-memory subsystem with a registered request/ack handshake.
// Defining MEM_SUBSYS_FAULT_EN adds the fault output for unmapped accesses.
module mem_subsystem
    import mem_subsys_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                RAM_DEPTH = 4096,
    parameter int                PORT_EXP  = 2,
    parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(MMIO_BASE_DEFAULT),
    parameter int                MMIO_WAIT = 2,
    localparam int               NREG      = 2 * (2 ** PORT_EXP)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] d_out,
    input  logic [DATA_W-1:0] port_d_in  [NREG],
    output logic [DATA_W-1:0] port_d_out [NREG],
    output logic [NREG-1:0]   port_wr_stb
`ifdef MEM_SUBSYS_FAULT_EN
    ,
    output logic              fault
`endif
);

    localparam int              KW       = PORT_EXP + 1;
    localparam int              RAM_AW   = $clog2(RAM_DEPTH);
    localparam logic [ADDR_W:0] RAM_END  = (ADDR_W+1)'(RAM_DEPTH);
    localparam logic [ADDR_W:0] NREG_END = (ADDR_W+1)'(NREG);

    state_e            state_q;
    logic              ready_q;
    logic              ack_q;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] d_out_q;
    logic [NREG-1:0]   stb_q;
    logic [DATA_W-1:0] port_d_out_q [NREG];

    logic              wr_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [KW-1:0]     k_q;
    logic [DATA_W-1:0] wdata_q;

    region_e           region;
    logic [ADDR_W-1:0] offset;
    logic              accept;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    function automatic logic [NREG-1:0] onehot(input logic [KW-1:0] k);
        onehot    = '0;
        onehot[k] = 1'b1;
    endfunction

    assign offset = addr - MMIO_BASE;

    always_comb begin
        region = REG_NONE;
        if ({1'b0, addr} < RAM_END) begin
            region = REG_RAM;
        end else if (addr >= MMIO_BASE && {1'b0, offset} < NREG_END) begin
            region = REG_MMIO;
        end
    end

    assign accept = (state_q == IDLE) && req && (read || write);

    // Reads are launched on the accept edge so the data is ready by the end of RAM.
    assign ram_addr = (state_q == IDLE) ? addr[RAM_AW-1:0] : ram_addr_q;
    assign ram_re   = accept && (region == REG_RAM) && !write;
    assign ram_we   = (state_q == RAM) && wr_q;

    mem_subsys_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (RAM_DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q       <= write;
            ram_addr_q <= addr[RAM_AW-1:0];
            k_q        <= offset[KW-1:0];
            wdata_q    <= d_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
            d_out_q <= '0;
            stb_q   <= '0;
            for (int i = 0; i < NREG; i++) begin
                port_d_out_q[i] <= '0;
            end
        end else begin
            ack_q <= 1'b0;
            stb_q <= '0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        case (region)
                            REG_RAM: state_q <= RAM;
                            REG_MMIO: begin
                                state_q <= MMIO;
                                cnt_q   <= 4'(MMIO_WAIT);
                                if (write && MMIO_WAIT == 0) begin
                                    stb_q <= onehot(offset[KW-1:0]);
                                end
                            end
                            default: begin
                                state_q <= RESP;
                                ack_q   <= 1'b1;
                                if (!write) begin
                                    d_out_q <= '0;
                                end
                            end
                        endcase
                    end
                end
                RAM: begin
                    state_q <= RESP;
                    ack_q   <= 1'b1;
                    if (!wr_q) begin
                        d_out_q <= ram_rdata;
                    end
                end
                MMIO: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                        ack_q   <= 1'b1;
                        if (wr_q) begin
                            port_d_out_q[k_q] <= wdata_q;
                        end else begin
                            d_out_q <= port_d_in[k_q];
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        // Strobe is registered one cycle early so it lines up with the access cycle.
                        if (cnt_q == 4'd1 && wr_q) begin
                            stb_q <= onehot(k_q);
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MEM_SUBSYS_FAULT_EN
    logic fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= accept && (region == REG_NONE);
        end
    end

    assign fault = fault_q;
`endif

    assign ready       = ready_q;
    assign ack         = ack_q;
    assign d_out       = d_out_q;
    assign port_wr_stb = stb_q;
    assign port_d_out  = port_d_out_q;

endmodule

// File: doc/mem_subsystem.md
# mem_subsystem

Parametrised memory subsystem that serves the core's single data-memory port. It decodes each address into a RAM region, an MMIO port-register region or an unmapped hole. Each access goes through a registered request/acknowledge handshake. MMIO accesses take a configurable number of wait states, and every MMIO write produces a per-port write strobe. It sits between the core's load/store stage and the external I/O ports, replacing the flat RAM-OR-MMIO data path with a decoded, multi-cycle path.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 16, address width
- RAM_DEPTH, 4096, RAM words, mapped at address 0
- PORT_EXP, 2, port count is 2**PORT_EXP; each port owns 2 words, so NREG = 2*2**PORT_EXP
- MMIO_BASE, 16'hFF00, first MMIO address; must be ≥ RAM_DEPTH and MMIO_BASE+NREG ≤ 2**ADDR_W
- MMIO_WAIT, 2, extra wait cycles per MMIO access (0..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  access request
- read  in  1  read access
- write  in  1  write access; if both read and write are high, the write wins
- addr  in  ADDR_W  word address
- d_in  in  DATA_W  write data
- ready  out  1  high when a request can be accepted
- ack  out  1  one-cycle completion pulse
- d_out  out  DATA_W  read data, valid on ack and held until the next ack
- port_d_in  in  NREG×DATA_W  unpacked input words from the ports
- port_d_out  out  NREG×DATA_W  unpacked output registers
- port_wr_stb  out  NREG  one-cycle pulse per written register
- fault  out  1  present only with MEM_SUBSYS_FAULT_EN

## Operation
- FSM states:
  - IDLE: ready=1.
  - RAM: RAM access in flight, one cycle.
  - MMIO: wait counter running.
  - RESP: ack=1.
- IDLE & req & (read|write):
  - Latch addr, d_in, op, region.
  - Go to RAM for the RAM region.
  - Go to MMIO for the MMIO region, loading the counter with MMIO_WAIT.
  - Go to RESP for unmapped addresses.
- IDLE & req with neither read nor write: ignored, stays in IDLE.
- RAM state:
  - A write updates mem[addr].
  - A read registers mem[addr] into d_out.
  - Then go to RESP.
- MMIO state:
  - Decrement the counter.
  - When the counter is 0, perform the access and go to RESP.
  - Write: port_d_out[k] <= d_in and port_wr_stb[k]=1 for that cycle, where k = addr-MMIO_BASE.
  - Read: d_out <= port_d_in[k], sampled in that same cycle.
- RESP: ack=1 for one cycle, then return to IDLE. ready is low in RESP, so the next request is accepted at the earliest on the following cycle.
- Unmapped write: dropped. Unmapped read: d_out <= 0.
- RAM writes never alter d_out; d_out changes only on read completion.
- req, read, write, addr and d_in are sampled only in IDLE; changes while busy have no effect.
- Reset (asynchronous, any state): FSM→IDLE, ready=1, ack=0, d_out=0, port_d_out all 0, port_wr_stb=0, fault=0, counter=0. RAM contents are not reset. An in-flight access is abandoned and no ack is issued.

## Timing
- Request accepted at edge T:
  - RAM: ack high in cycle T+2.
  - MMIO: ack high in cycle T+2+MMIO_WAIT.
  - Unmapped: ack high in cycle T+1.
- port_wr_stb fires one cycle before the matching ack.
- ready=0 from the cycle after acceptance until the cycle after ack.
- Back-to-back RAM throughput: one access per 3 cycles.
- Address compare is unsigned at ADDR_W width. k is taken from the low PORT_EXP+1 bits of addr-MMIO_BASE after the range check.

## Configuration
- MEM_SUBSYS_FAULT_EN defined:
  - The fault output exists.
  - fault is high together with ack for an unmapped access.
  - fault is high together with ack for a write to address ≥ RAM_DEPTH and < MMIO_BASE.
  - fault is otherwise 0.
- MEM_SUBSYS_FAULT_EN undefined: the port is absent, and unmapped accesses complete silently as described above.

## Structure
- Shared package mem_subsys_pkg holds:
  - the state enum (IDLE, RAM, MMIO, RESP);
  - the region enum (REG_RAM, REG_MMIO, REG_NONE);
  - the default MMIO_BASE constant.
- One sub-module, mem_subsys_ram: single-port synchronous RAM of RAM_DEPTH×DATA_W with a registered read.
- Decode, FSM and MMIO registers live in the top level.

## Test plan
- Reset mid-MMIO wait:
  - Stimulus: write 16'h1234 to MMIO_BASE+1, then assert rst_n low during the wait.
  - Required: ack never pulses, port_d_out[1]=0, ready=1 immediately.
- RAM write then read:
  - Stimulus: write 16'hBEEF at 16'h0010, then read 16'h0010.
  - Required: each ack 2 cycles after acceptance; d_out=16'hBEEF on the second ack.
- MMIO write with MMIO_WAIT=2:
  - Stimulus: write 16'hA5A5 to 16'hFF03.
  - Required: port_wr_stb=8'b0000_1000 for one cycle, port_d_out[3]=16'hA5A5, ack 4 cycles after acceptance.
- MMIO read:
  - Stimulus: drive port_d_in[6]=16'h0F0F, then read 16'hFF06.
  - Required: d_out=16'h0F0F on ack; d_out holds that value through following RAM writes.
- Unmapped access with MEM_SUBSYS_FAULT_EN defined:
  - Stimulus: read 16'h8000.
  - Required: ack and fault high in cycle T+1, d_out=0.
  - Same read without the macro: ack only, no fault port.
- Busy and priority:
  - Stimulus: request with read=write=1 to RAM 16'h0002 with d_in=16'h0007; hold req high with a different addr while busy.
  - Required: the write occurs, the second request is accepted only after ready returns high, and addr changes while busy have no effect.
